player_input: RTL and testbench

Conditions the four raw player push-buttons of the Simon game into the `playerNum`/`playerPressed` pair consumed by the Simon game controller. It sits directly upstream of the controller. Each button is synchronised and debounced. A clean single-button press produces exactly one one-cycle pulse carrying the button index. Multi-button presses are rejected, and every press must be fully released before the next one is accepted.

---
 rtl/player_input.sv | 123 ++++++++++++
 tb/tb_player_input.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/player_input.sv
// Synchronises, debounces and arbitrates the four Simon push-buttons into a single press pulse.
// Optional macro PLAYER_INPUT_LOCKOUT_EN suppresses presses while simonTurn is high.
module player_input #(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       simonTurn,
  output logic [1:0] playerNum,
  output logic       playerPressed,
  output logic       multiPress
);

  typedef enum logic {IDLE, HELD} state_t;

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_TICKS - 1);

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] st;
  logic [3:0] cnt [4];

  state_t     state;
  state_t     state_n;
  logic [1:0] num_n;
  logic       pressed_n;
  logic       multi_n;
  logic       lock;

  function automatic logic [1:0] btn_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

`ifdef PLAYER_INPUT_LOCKOUT_EN
  assign lock = simonTurn;
`else
  logic unused_simon_turn;
  assign unused_simon_turn = simonTurn;
  assign lock = 1'b0;
`endif

  // Stage 1: two-flop synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 4'd0;
      s2 <= 4'd0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Stage 2: per-button debounce; a level is accepted only after DEBOUNCE_TICKS stable cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= 4'd0;
      for (int i = 0; i < 4; i++) cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= 4'd0;
        end else if (cnt[i] == CNT_MAX) begin
          st[i]  <= s2[i];
          cnt[i] <= 4'd0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // Stage 3: press arbitration; every press must be fully released before the next one counts
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      playerNum     <= 2'd0;
      playerPressed <= 1'b0;
      multiPress    <= 1'b0;
    end else begin
      state         <= state_n;
      playerNum     <= num_n;
      playerPressed <= pressed_n;
      multiPress    <= multi_n;
    end
  end

  always_comb begin
    state_n   = state;
    num_n     = playerNum;
    pressed_n = 1'b0;
    multi_n   = 1'b0;
    case (state)
      IDLE: begin
        if (st != 4'd0) begin
          state_n = HELD;
          if (!lock) begin
            if (is_onehot(st)) begin
              pressed_n = 1'b1;
              num_n     = btn_index(st);
            end else begin
              multi_n = 1'b1;
            end
          end
        end
      end
      HELD: begin
        if (st == 4'd0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_player_input.sv
// Directed-vector bench for player_input at DEBOUNCE_TICKS = 3.
module tb_player_input;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       simonTurn;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic       multiPress;

  int n_checks = 0;
  int n_fail   = 0;
  int press_cnt = 0;
  int multi_cnt = 0;
  int both_cnt  = 0;

  player_input #(.DEBOUNCE_TICKS(3)) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .simonTurn(simonTurn),
    .playerNum(playerNum),
    .playerPressed(playerPressed),
    .multiPress(multiPress)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later and tally pulses.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (playerPressed) press_cnt++;
      if (multiPress) multi_cnt++;
      if (playerPressed && multiPress) both_cnt++;
    end
  endtask

  task automatic clear_counts();
    press_cnt = 0;
    multi_cnt = 0;
  endtask

  initial begin
    reset = 1'b1;
    btn = 4'd0;
    simonTurn = 1'b0;
    step(2);
    reset = 1'b0;
    check("reset_num", playerNum, 0);
    check("reset_pressed", playerPressed, 0);
    check("reset_multi", multiPress, 0);

    // Single press of button 2: pulse registered at E5 (6th sampled edge).
    clear_counts();
    btn = 4'b0100;
    step(5);
    check("b2_no_early_pulse", playerPressed, 0);
    step(1);
    check("b2_pulse_at_e5", playerPressed, 1);
    check("b2_num", playerNum, 2);
    step(1);
    check("b2_pulse_one_cycle", playerPressed, 0);
    step(3);
    btn = 4'd0;
    step(10);
    check("b2_press_count", press_cnt, 1);
    check("b2_multi_count", multi_cnt, 0);
    check("b2_num_held", playerNum, 2);

    // Two-cycle glitch is rejected.
    clear_counts();
    btn = 4'b0010;
    step(2);
    btn = 4'd0;
    step(10);
    check("glitch2_press", press_cnt, 0);
    check("glitch2_multi", multi_cnt, 0);

    // Three-cycle press is accepted.
    btn = 4'b0010;
    step(3);
    btn = 4'd0;
    step(12);
    check("b1_3cyc_press", press_cnt, 1);
    check("b1_3cyc_num", playerNum, 1);

    // Simultaneous buttons 0 and 3.
    clear_counts();
    btn = 4'b1001;
    step(8);
    btn = 4'd0;
    step(10);
    check("multi_pulse", multi_cnt, 1);
    check("multi_no_press", press_cnt, 0);
    check("multi_num_kept", playerNum, 1);
    clear_counts();
    btn = 4'b1000;
    step(8);
    btn = 4'd0;
    step(10);
    check("after_multi_press", press_cnt, 1);
    check("after_multi_num", playerNum, 3);

    // Button added while held is ignored.
    clear_counts();
    btn = 4'b0001;
    step(8);
    btn = 4'b1001;
    step(8);
    btn = 4'd0;
    step(10);
    check("held_add_press", press_cnt, 1);
    check("held_add_multi", multi_cnt, 0);
    check("held_add_num", playerNum, 0);
    clear_counts();
    btn = 4'b1000;
    step(8);
    btn = 4'd0;
    step(10);
    check("post_held_press", press_cnt, 1);
    check("post_held_num", playerNum, 3);

    // Press during simonTurn, held across the turn flag dropping.
    clear_counts();
    simonTurn = 1'b1;
    btn = 4'b0100;
    step(8);
    simonTurn = 1'b0;
    step(8);
    btn = 4'd0;
    step(10);
`ifdef PLAYER_INPUT_LOCKOUT_EN
    check("turn_press", press_cnt, 0);
    check("turn_num", playerNum, 3);
`else
    check("turn_press", press_cnt, 1);
    check("turn_num", playerNum, 2);
`endif
    check("turn_multi", multi_cnt, 0);
    clear_counts();
    btn = 4'b0100;
    step(8);
    btn = 4'd0;
    step(10);
    check("after_turn_press", press_cnt, 1);
    check("after_turn_num", playerNum, 2);

    // Reset while button 1 is held.
    clear_counts();
    btn = 4'b0010;
    step(8);
    check("pre_reset_press", press_cnt, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midreset_num", playerNum, 0);
    check("midreset_pressed", playerPressed, 0);
    check("midreset_multi", multiPress, 0);
    clear_counts();
    step(5);
    check("postreset_no_early", press_cnt, 0);
    step(1);
    check("postreset_pulse", playerPressed, 1);
    check("postreset_num", playerNum, 1);
    step(4);
    btn = 4'd0;
    step(10);
    check("postreset_count", press_cnt, 1);
    check("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
